pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..512.
REQ-002 SHALL have parameter RESET_VAL, default all-zero WIDTH bits: value loaded into the payload registers by reset.
REQ-003 SHALL have parameter FLUSH_VAL, default all-zero WIDTH bits: value loaded into the payload registers by flush (e.g. a NOP encoding).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port flush_valid_i, input, 1 bit: discard all held entries.
REQ-007 SHALL have port in_valid_i, input, 1 bit: upstream offers a payload.
REQ-008 SHALL have port in_ready_o, output, 1 bit: stage accepts a payload this cycle.
REQ-009 SHALL have port in_data_i, input, WIDTH bits: upstream payload.
REQ-010 SHALL have port out_valid_o, output, 1 bit: out_data_o holds a valid payload.
REQ-011 SHALL have port out_ready_i, input, 1 bit: downstream accepts the payload.
REQ-012 SHALL have port out_data_o, output, WIDTH bits: payload from the main register.
REQ-013 SHALL have port count_o, output, 2 bits: number of held entries (0, 1 or 2).

Function
REQ-014 SHALL implement a 2-entry elastic stage: a main register drives out_data_o, and a skid register absorbs one beat when downstream stalls.
REQ-015 SHALL define in-fire as in_valid_i & in_ready_o, and out-fire as out_valid_o & out_ready_i.
REQ-016 SHALL use three states, EMPTY (count 0), ONE (count 1) and TWO (count 2), with count_o equal to the state occupancy.
REQ-017 SHALL drive in_ready_o = (state != TWO) and out_valid_o = (state != EMPTY), decoded from registered state only, with no combinational path from any input.
REQ-018 SHALL, in EMPTY on in-fire, move to ONE and load main from in_data_i.
REQ-019 SHALL, in ONE on in-fire with out-fire, stay in ONE and load main from in_data_i.
REQ-020 SHALL, in ONE on in-fire without out-fire, move to TWO and load skid from in_data_i.
REQ-021 SHALL, in ONE on out-fire without in-fire, move to EMPTY with main unchanged.
REQ-022 SHALL, in TWO on out-fire, move to ONE and load main from skid; no input is accepted in TWO.
REQ-023 SHALL have latency of 1 cycle: in EMPTY, a payload accepted at edge N is visible at out_data_o with out_valid_o=1 after edge N.
REQ-024 SHALL sustain throughput of one beat per cycle when out_ready_i is held at 1.
REQ-025 SHALL deliver payloads in order with none duplicated or lost, except on flush.
REQ-026 SHALL give flush priority over all other events: on the next edge, state becomes EMPTY and main and skid load FLUSH_VAL.
REQ-027 SHALL, when flush coincides with in-fire, discard the input beat; when flush coincides with out-fire, treat the beat as consumed downstream.
REQ-028 SHALL keep main and skid unchanged while no fire and no flush occurs; out_data_o is stable while out_valid_o=1 and out_ready_i=0.
REQ-029 SHALL ignore in_data_i when no in-fire occurs.

Reset
REQ-030 SHALL, while rst=1, immediately force state EMPTY and main = skid = RESET_VAL, independent of clk.
REQ-031 SHALL hold outputs during reset at out_valid_o=0, in_ready_o=1, count_o=0 and out_data_o=RESET_VAL.
REQ-032 SHALL abandon held entries on reset asserted mid-operation; the first edge after rst falls behaves as EMPTY.

Structure
REQ-033 SHALL place the state encoding (EMPTY/ONE/TWO, 2 bits) in the shared pipeline package.
REQ-034 SHALL implement the stage as a single module with no sub-module; payload registers are inline so they carry the asynchronous reset.
REQ-035 SHALL be usable as a drop-in replacement for each fixed inter-stage register by concatenating that stage's fields into in_data_i.

Verification (WIDTH=32, RESET_VAL=0, FLUSH_VAL=32'h00000013)
REQ-036 SHALL verify streaming: 3 beats A1,A2,A3 on consecutive cycles with out_ready_i=1 -> same 3 beats out, 1-cycle latency, count_o=1 throughout.
REQ-037 SHALL verify stall fill: send B1,B2 with out_ready_i=0 -> count_o=2, in_ready_o=0, out_data_o=B1; raise out_ready_i -> B1 then B2 out, in_ready_o returns to 1 after the first out-fire.
REQ-038 SHALL verify flush: in TWO, assert flush_valid_i with in_valid_i=1 (C3) -> next cycle count_o=0, out_valid_o=0, out_data_o=32'h00000013, C3 never emitted.
REQ-039 SHALL verify async reset: in TWO, pulse rst between edges -> outputs reach reset values (REQ-031) before the next edge; next beat D1 emerges normally.
REQ-040 SHALL verify simultaneous events: ONE with in-fire and out-fire each cycle for 100 random beats under random out_ready_i -> scoreboard exact order match, no loss.
REQ-041 SHALL verify width corner: WIDTH=1, toggle pattern 0,1,0,1 under alternating out_ready_i -> order preserved.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: occupancy-state encoding for the elastic skid stage.
package pipe_skid_stage_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned COUNT_W = 2;

  typedef enum logic [STATE_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Number of held entries represented by a state.
  function automatic logic [COUNT_W-1:0] state_count(input skid_state_e s);
    logic [COUNT_W-1:0] c;
    c = COUNT_W'(0);
    case (s)
      ONE:     c = COUNT_W'(1);
      TWO:     c = COUNT_W'(2);
      default: c = COUNT_W'(0);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline stage: main register feeds downstream, skid register
// absorbs the beat accepted while downstream stalls. Handshake outputs decode state only.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_valid_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [COUNT_W-1:0] count_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign count_o     = state_count(state_q);

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // State and payload registers share the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and payload moves; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_valid_i) begin
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a queue-based occupancy model drives expectations for a
// 32-bit instance and a 1-bit instance under directed and random handshakes.
module tb_pipe_skid_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] FV  = 32'h0000_0013;
  localparam logic        RV1 = 1'b1;
  localparam logic        FV1 = 1'b0;

  typedef logic [31:0] word_q_t[$];

  logic        clk;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  count;
  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic        in_data1, out_data1;
  logic [1:0]  count1;

  word_q_t     mq, mq1, tx, rx, rx1;
  logic [31:0] ms, ms1;
  int          tests, failed;

  pipe_skid_stage #(.WIDTH(32), .RESET_VAL(RV), .FLUSH_VAL(FV)) dut (
    .clk(clk), .rst(rst), .flush_valid_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count)
  );

  pipe_skid_stage #(.WIDTH(1), .RESET_VAL(RV1), .FLUSH_VAL(FV1)) dut1 (
    .clk(clk), .rst(rst), .flush_valid_i(flush1),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_data_i(in_data1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_data_o(out_data1),
    .count_o(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stage viewed as a FIFO of at most two entries plus the last value shown downstream.
  task automatic model_step(input word_q_t qi, input logic [31:0] si, input logic fl,
                            input logic iv, input logic [31:0] id, input logic ordy,
                            input logic [31:0] fv, output word_q_t qo,
                            output logic [31:0] so, output logic acc);
    logic pop;
    qo  = qi;
    so  = si;
    acc = 1'b0;
    pop = (qi.size() > 0) && ordy;
    if (fl) begin
      qo.delete();
      so = fv;
    end else begin
      acc = iv && (qi.size() < 2);
      if (pop) void'(qo.pop_front());
      if (acc) qo.push_back(id);
      if (qo.size() > 0) so = qo[0];
    end
  endtask

  task automatic check_outputs();
    check("count",      32'(count),      32'(mq.size()));
    check("in_ready",   32'(in_ready),   32'(mq.size() < 2));
    check("out_valid",  32'(out_valid),  32'(mq.size() > 0));
    check("out_data",   out_data,        ms);
    check("w1_count",   32'(count1),     32'(mq1.size()));
    check("w1_in_rdy",  32'(in_ready1),  32'(mq1.size() < 2));
    check("w1_out_vld", 32'(out_valid1), 32'(mq1.size() > 0));
    check("w1_out_dat", {31'b0, out_data1}, ms1);
  endtask

  task automatic cycle();
    word_q_t     nq, nq1;
    logic [31:0] ns, ns1;
    logic        a, a1;
    model_step(mq, ms, flush, in_valid, in_data, out_ready, FV, nq, ns, a);
    model_step(mq1, ms1, flush1, in_valid1, {31'b0, in_data1}, out_ready1,
               {31'b0, FV1}, nq1, ns1, a1);
    if (a) tx.push_back(in_data);
    if (out_valid && out_ready) rx.push_back(out_data);
    if (out_valid1 && out_ready1) rx1.push_back({31'b0, out_data1});
    @(posedge clk);
    #1;
    mq  = nq;
    ms  = ns;
    mq1 = nq1;
    ms1 = ns1;
    check_outputs();
  endtask

  task automatic model_reset();
    mq.delete();
    mq1.delete();
    ms  = RV;
    ms1 = {31'b0, RV1};
  endtask

  // Reset pulse wholly between two rising edges.
  task automatic reset_pulse();
    #1 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
  endtask

  logic pat[4];

  initial begin
    tests = 0; failed = 0;
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 1'b0; out_ready1 = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    rst = 1'b0;

    // Streaming at full rate.
    out_ready = 1'b1;
    send(32'hA1A1_0001);
    send(32'hA2A2_0002);
    send(32'hA3A3_0003);
    in_valid = 1'b0;
    cycle(); cycle();

    // Stall fill, then drain; a beat offered while full must be refused.
    out_ready = 1'b0;
    send(32'hB1B1_0001);
    send(32'hB2B2_0002);
    send(32'hB3B3_0003);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle(); cycle();

    // Flush while full with a coincident input beat.
    out_ready = 1'b0;
    send(32'hC1C1_0001);
    send(32'hC2C2_0002);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hC3C3_0003;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    // Asynchronous reset while full, then a normal beat.
    out_ready = 1'b0;
    send(32'hD0D0_000A);
    send(32'hD0D0_000B);
    in_valid = 1'b0;
    reset_pulse();
    send(32'hD1D1_0001);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    // Random handshakes: 100 accepted beats must leave in order.
    tx.delete(); rx.delete();
    for (int c = 0; c < 2000 && tx.size() < 100; c++) begin
      in_valid  = ($urandom_range(0, 9) != 0);
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("rand_accepted", 32'(tx.size()), 32'd100);
    check("rand_emitted",  32'(rx.size()), 32'(tx.size()));
    for (int i = 0; i < tx.size() && i < rx.size(); i++)
      check("rand_order", rx[i], tx[i]);

    // One-bit payload toggle under alternating downstream ready.
    pat = '{1'b0, 1'b1, 1'b0, 1'b1};
    rx1.delete();
    begin
      int k;
      k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
        logic take;
        take       = (mq1.size() < 2);
        in_valid1  = 1'b1;
        in_data1   = pat[k];
        out_ready1 = 1'(c % 2);
        cycle();
        if (take) k++;
      end
    end
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    cycle(); cycle(); cycle();
    check("w1_emitted", 32'(rx1.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx1.size(); i++)
      check("w1_order", rx1[i], {31'b0, pat[i]});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
